// File: rtl/sprite_palette_ram.sv
// Runtime-loadable sprite colour palette: index -> RGB with one registered cycle,
// transparency-key flag and a frame-timed white hit-flash override.
module sprite_palette_ram #(
    parameter int IDX_W        = 4,
    parameter int CH_W         = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [3*CH_W-1:0] wr_rgb,
    input  logic              rd_valid,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic              frame_tick,
    input  logic              flash_start,
    output logic              out_valid,
    output logic [CH_W-1:0]   red,
    output logic [CH_W-1:0]   green,
    output logic [CH_W-1:0]   blue,
    output logic              transparent,
    output logic              flash_active,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int RGB_W = 3 * CH_W;
    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   init_ptr_r;
    logic [CNT_W-1:0]   flash_cnt_r;
    logic [CNT_W-1:0]   flash_cnt_s;
    logic [RGB_W-1:0]   mem_r [DEPTH];
    logic               wr_fire_s;
    logic               key_hit_s;
    logic [RGB_W-1:0]   lookup_s;
    logic [RGB_W-1:0]   pixel_s;

    assign wr_ready  = (state_r == ST_RUN);
    assign init_busy = (state_r == ST_INIT);
    assign wr_fire_s = wr_valid && wr_ready;

    // Next flash count: a (re)start reloads and swallows any coincident tick.
    always_comb begin
        flash_cnt_s = flash_cnt_r;
        if (flash_start && (state_r == ST_RUN)) begin
            flash_cnt_s = CNT_W'(FLASH_FRAMES);
        end else if (frame_tick && (flash_cnt_r != {CNT_W{1'b0}})) begin
            flash_cnt_s = flash_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flash_cnt_s = flash_cnt_r;
        end
    end

    // Pixel value presented to the output register, write-first on collision.
    always_comb begin
        key_hit_s = rd_valid && (rd_index == IDX_W'(TRANSP_IDX));
        lookup_s  = {RGB_W{1'b0}};
        if (state_r != ST_RUN) begin
            lookup_s = {RGB_W{1'b0}};
        end else if (wr_fire_s && (wr_index == rd_index)) begin
            lookup_s = wr_rgb;
        end else begin
            lookup_s = mem_r[rd_index];
        end
        if (!rd_valid) begin
            pixel_s = {RGB_W{1'b0}};
        end else if (flash_active && !key_hit_s) begin
            pixel_s = {RGB_W{1'b1}};
        end else begin
            pixel_s = lookup_s;
        end
    end

    // Control state: init sweep pointer, FSM and flash counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_INIT;
            init_ptr_r   <= {IDX_W{1'b0}};
            flash_cnt_r  <= {CNT_W{1'b0}};
            flash_active <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_ptr_r <= init_ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (init_ptr_r == IDX_W'(DEPTH - 1)) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN:  state_r <= ST_RUN;
                default: state_r <= ST_INIT;
            endcase
            flash_cnt_r  <= flash_cnt_s;
            flash_active <= (flash_cnt_s != {CNT_W{1'b0}});
        end
    end

    // Palette storage: cleared entry by entry during INIT, loaded by the write port in RUN.
    always_ff @(posedge Clk) begin
        if (state_r == ST_INIT) begin
            mem_r[init_ptr_r] <= {RGB_W{1'b0}};
        end else if (wr_fire_s) begin
            mem_r[wr_index] <= wr_rgb;
        end
    end

    // Registered lookup outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid   <= 1'b0;
            transparent <= 1'b0;
            red         <= {CH_W{1'b0}};
            green       <= {CH_W{1'b0}};
            blue        <= {CH_W{1'b0}};
        end else begin
            out_valid   <= rd_valid;
            transparent <= key_hit_s;
            red         <= pixel_s[3*CH_W-1:2*CH_W];
            green       <= pixel_s[2*CH_W-1:CH_W];
            blue        <= pixel_s[CH_W-1:0];
        end
    end

endmodule

// File: doc/sprite_palette_ram.md
Name: sprite_palette_ram

Overview:
Writable, parametrised colour palette for sprite layers. It maps a per-pixel colour index to RGB with one cycle of registered latency. Contents are loaded at runtime through a valid/ready write port, replacing fixed per-sprite palette ROMs. It also flags the transparency-key index and applies a frame-timed hit-flash override. It sits between the sprite ROM index output and the VGA colour mux.

Parameters:
IDX_W, 4, colour-index width; palette depth = 2**IDX_W entries
CH_W, 4, bits per colour channel
TRANSP_IDX, 0, index treated as transparent (key colour)
FLASH_FRAMES, 8, frame_tick count for one hit flash (>=1)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
wr_valid  in  1  write request
wr_ready  out  1  palette can accept a write
wr_index  in  IDX_W  entry to write
wr_rgb  in  3*CH_W  {red,green,blue} for entry
rd_valid  in  1  pixel lookup request
rd_index  in  IDX_W  pixel colour index
frame_tick  in  1  one-cycle pulse per video frame (vsync edge)
flash_start  in  1  one-cycle pulse: begin/retrigger hit flash
out_valid  out  1  registered rd_valid
red, green, blue  out  CH_W each  looked-up colour
transparent  out  1  looked-up index == TRANSP_IDX
flash_active  out  1  flash override in progress
init_busy  out  1  palette clear in progress

Behaviour:
- Storage: 2**IDX_W x 3*CH_W array. Write accepted on the cycle wr_valid && wr_ready.
- Reset (sync, any state, including mid-init or mid-flash):
  - Next state INIT; init pointer = 0; init_busy = 1; wr_ready = 0.
  - out_valid, red, green, blue, transparent, flash_active = 0; flash counter = 0.
- FSM INIT:
  - Writes all-zero to entry[ptr] each cycle; ptr increments.
  - After writing entry 2**IDX_W-1, moves to RUN. INIT lasts exactly 2**IDX_W cycles after Reset deasserts.
  - wr_ready = 0 throughout INIT.
- FSM RUN: init_busy = 0, wr_ready = 1 (combinational from state). Stays in RUN until Reset.
- Read pipeline, 1-cycle latency. Cycle N request produces cycle N+1 outputs:
  - out_valid = rd_valid.
  - transparent = rd_valid && rd_index==TRANSP_IDX.
  - {red,green,blue} = entry[rd_index].
  - rd_valid=0: colour outputs = 0, transparent = 0.
- Read/write collision: a same-cycle accepted write to rd_index bypasses, so the read returns the new wr_rgb (write-first).
- Reads during INIT: out_valid follows rd_valid; colour returns 0.
- Flash:
  - flash_start (in RUN) loads counter = FLASH_FRAMES and sets flash_active = 1 next cycle.
  - Each frame_tick while counter>0 decrements the counter. flash_active = (counter != 0).
  - flash_start and frame_tick in the same cycle: reload wins, with no decrement.
  - flash_start during INIT is ignored.
- Flash override: when flash_active at output-register time and the read is valid and non-transparent, all channels = {CH_W{1'b1}} (white).
  - Transparent pixels keep their stored colour and transparent = 1.
  - The override uses the flash_active value registered in the same cycle as the lookup.
- Widths: wr_rgb split as red = [3*CH_W-1:2*CH_W], green = middle, blue = [CH_W-1:0]. No arithmetic on channels.

Test Plan:
- Reset held 3 cycles, release -> init_busy=1 and wr_ready=0 for exactly 16 cycles (IDX_W=4); then init_busy=0, wr_ready=1. A read of index 5 then returns 0,0,0 with out_valid one cycle after rd_valid.
- Write idx 3 = 12'hA0A in RUN, read idx 3 next cycle -> out_valid=1, red=A, green=0, blue=A, transparent=0, one cycle after the request.
- Same-cycle write idx 7 = 12'h123 and read idx 7 -> the next cycle outputs 1,2,3 (bypass). Read idx 0 -> transparent=1.
- flash_start, then 8 frame_ticks spaced 10 cycles apart -> flash_active=1 from the cycle after start until the 8th tick. Reads of non-key idx 3 give F,F,F during the flash; reads of idx 0 keep the stored colour with transparent=1.
- flash_start coincident with the 5th frame_tick -> counter reloads to 8, and flash ends 8 ticks later, not 3.
- Reset asserted mid-flash and mid-write stream -> next cycle flash_active=0, wr_ready=0, out_valid=0. A full 16-cycle INIT is repeated, and the previously written idx 3 reads back 0.
